// File: rtl/cache_pkg.sv
// Shared cache geometry, miss-handler state encoding and fill constants.
package cache_pkg;
  localparam int TAG_W  = 27;
  localparam int IDX_W  = 3;
  localparam int WORD_W = 32;
  localparam int WORDS  = 4;
  localparam int LINE_W = WORDS * WORD_W;
  localparam int BEAT_W = 2;

  localparam logic [BEAT_W-1:0] LAST_BEAT    = BEAT_W'(WORDS - 1);
  localparam logic [WORDS-1:0]  REGWRITE_ALL = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FILL,
    WRITE,
    DONE
  } miss_state_t;
endpackage

// File: rtl/fill_buffer.sv
// Word-addressed line buffer that collects read beats into one cache line.
module fill_buffer
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [BEAT_W-1:0]    beat,
  input  logic [WORD_W-1:0]    din,
  output logic [LINE_W-1:0]    line
);
  logic [WORDS-1:0][WORD_W-1:0] words;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words <= '0;
    end else if (we) begin
      words[beat] <= din;
    end
  end

  assign line = words;
endmodule

// File: rtl/miss_refill_ctrl.sv
// Data-cache miss handler: writes back a dirty victim, refills the line from
// the 32-bit memory port and installs it into cacheLine in a single cycle.
module miss_refill_ctrl
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 missReq,
  input  logic [TAG_W-1:0]     missTag,
  input  logic [IDX_W-1:0]     missIdx,
  input  logic                 victimValid,
  input  logic                 victimDirty,
  input  logic [TAG_W-1:0]     victimTag,
  input  logic [LINE_W-1:0]    victimData,
  output logic                 memReq,
  output logic                 memWe,
  output logic [31:0]          memAddr,
  output logic [WORD_W-1:0]    memWData,
  input  logic                 memAck,
  input  logic [WORD_W-1:0]    memRData,
  output logic [WORDS-1:0]     regWrite,
  output logic [LINE_W-1:0]    writeData,
  output logic [TAG_W-1:0]     writeTag,
  output logic [IDX_W-1:0]     writeIdx,
  output logic                 busy,
  output logic                 done
);
  miss_state_t         state, nextState;
  logic [BEAT_W-1:0]   beat;
  logic [TAG_W-1:0]    missTagQ, victimTagQ;
  logic [IDX_W-1:0]    idxQ;
  logic [LINE_W-1:0]   victimDataQ;
  logic [LINE_W-1:0]   fillLine;
  logic                beatDone;
  logic                fillWe;

  assign beatDone = (state == WB || state == FILL) && memAck;
  assign fillWe   = (state == FILL) && memAck;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE) begin
        beat <= '0;
      end else if (beatDone) begin
        beat <= beat + 1'b1;
      end
    end
  end

  // Request fields are only ever read after the capture, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && missReq) begin
      missTagQ    <= missTag;
      idxQ        <= missIdx;
      victimTagQ  <= victimTag;
      victimDataQ <= victimData;
    end
  end

  fill_buffer uBuf (
    .clk   (clk),
    .reset (reset),
    .we    (fillWe),
    .beat  (beat),
    .din   (memRData),
    .line  (fillLine)
  );

  always_comb begin
    nextState = state;
    memReq    = 1'b0;
    memWe     = 1'b0;
    memAddr   = '0;
    memWData  = '0;
    regWrite  = '0;
    writeData = '0;
    writeTag  = '0;
    writeIdx  = '0;
    busy      = (state != IDLE);
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (missReq) nextState = (victimValid && victimDirty) ? WB : FILL;
      end
      WB: begin
        memReq   = 1'b1;
        memWe    = 1'b1;
        memAddr  = {victimTagQ, idxQ, beat};
        memWData = victimDataQ[WORD_W*beat +: WORD_W];
        if (memAck && beat == LAST_BEAT) nextState = FILL;
      end
      FILL: begin
        memReq  = 1'b1;
        memAddr = {missTagQ, idxQ, beat};
        if (memAck && beat == LAST_BEAT) nextState = WRITE;
      end
      WRITE: begin
        regWrite  = REGWRITE_ALL;
        writeData = fillLine;
        writeTag  = missTagQ;
        writeIdx  = idxQ;
        nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end
endmodule

// File: tb/tb_miss_refill_ctrl.sv
// Directed bench for miss_refill_ctrl: clean, dirty, wait-state and reset-abort misses.
`define CHK(tag, o, e) check(tag, 128'(o), 128'(e))

module tb_miss_refill_ctrl;
  logic         clk;
  logic         reset;
  logic         missReq;
  logic [26:0]  missTag;
  logic [2:0]   missIdx;
  logic         victimValid;
  logic         victimDirty;
  logic [26:0]  victimTag;
  logic [127:0] victimData;
  logic         memReq;
  logic         memWe;
  logic [31:0]  memAddr;
  logic [31:0]  memWData;
  logic         memAck;
  logic [31:0]  memRData;
  logic [3:0]   regWrite;
  logic [127:0] writeData;
  logic [26:0]  writeTag;
  logic [2:0]   writeIdx;
  logic         busy;
  logic         done;

  int passCnt  = 0;
  int totalCnt = 0;
  int cyc      = 0;
  int tReq;

  localparam logic [127:0] FILL_LINE = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

  miss_refill_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .missReq     (missReq),
    .missTag     (missTag),
    .missIdx     (missIdx),
    .victimValid (victimValid),
    .victimDirty (victimDirty),
    .victimTag   (victimTag),
    .victimData  (victimData),
    .memReq      (memReq),
    .memWe       (memWe),
    .memAddr     (memAddr),
    .memWData    (memWData),
    .memAck      (memAck),
    .memRData    (memRData),
    .regWrite    (regWrite),
    .writeData   (writeData),
    .writeTag    (writeTag),
    .writeIdx    (writeIdx),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns 0xA0 + word offset for every read beat.
  assign memRData = 32'hA0 + 32'(memAddr[1:0]);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #2;
    if (reset === 1'b1) begin
      totalCnt++;
      if (!(done === 1'b1 && regWrite !== 4'h0)) passCnt++;
      else $error("FAIL monDoneRegWrite: observed done=%0b regWrite=%0h expected exclusive", done, regWrite);
      totalCnt++;
      if (memReq !== 1'b1 || busy === 1'b1) passCnt++;
      else $error("FAIL monReqBusy: observed memReq=%0b busy=%0b expected busy", memReq, busy);
    end
  end

  task automatic runClean(input logic [26:0] tag, input logic [2:0] idx,
                          input logic vValid, input logic vDirty);
    missReq = 1'b1; missTag = tag; missIdx = idx;
    victimValid = vValid; victimDirty = vDirty;
    victimTag = 27'h3; victimData = {4{32'hDEADBEEF}};
    memAck = 1'b1;
    waitEdge();
    missReq = 1'b0;
    for (int k = 0; k < 4; k++) begin
      `CHK("fillReq", memReq, 1'b1);
      `CHK("fillWe", memWe, 1'b0);
      `CHK("fillAddr", memAddr, {tag, idx, 2'(k)});
      `CHK("fillNoRegWrite", regWrite, 4'h0);
      waitEdge();
    end
    `CHK("writeRegWrite", regWrite, 4'hF);
    `CHK("writeData", writeData, FILL_LINE);
    `CHK("writeTag", writeTag, tag);
    `CHK("writeIdx", writeIdx, idx);
    `CHK("writeNoDone", done, 1'b0);
    `CHK("writeNoReq", memReq, 1'b0);
    waitEdge();
    `CHK("donePulse", done, 1'b1);
    `CHK("doneNoRegWrite", regWrite, 4'h0);
    `CHK("doneBusy", busy, 1'b1);
    waitEdge();
    `CHK("idleDone", done, 1'b0);
    `CHK("idleBusy", busy, 1'b0);
  endtask

  initial begin
    reset = 1'b0; missReq = 1'b0; missTag = '0; missIdx = '0;
    victimValid = 1'b0; victimDirty = 1'b0; victimTag = '0; victimData = '0;
    memAck = 1'b0;
    repeat (2) waitEdge();
    `CHK("rstBusy", busy, 1'b0);
    `CHK("rstDone", done, 1'b0);
    `CHK("rstMemReq", memReq, 1'b0);
    `CHK("rstMemWe", memWe, 1'b0);
    `CHK("rstRegWrite", regWrite, 4'h0);
    `CHK("rstAddr", memAddr, 32'h0);
    `CHK("rstWData", memWData, 32'h0);
    `CHK("rstWriteData", writeData, 128'h0);
    `CHK("rstWriteTag", writeTag, 27'h0);
    `CHK("rstWriteIdx", writeIdx, 3'h0);
    reset = 1'b1;
    waitEdge();
    `CHK("postRstBusy", busy, 1'b0);

    // Clean miss, zero-wait memory (ack already high in IDLE is ignored).
    memAck = 1'b1;
    waitEdge();
    `CHK("ackInIdle", busy, 1'b0);
    runClean(27'h1234567, 3'd5, 1'b1, 1'b0);

    // Dirty victim; victim data altered mid-writeback, missReq pulsed during FILL.
    missReq = 1'b1; missTag = 27'h55; missIdx = 3'd2;
    victimValid = 1'b1; victimDirty = 1'b1; victimTag = 27'h7; victimData = 128'd256;
    memAck = 1'b1;
    waitEdge();
    missReq = 1'b0; missTag = 27'h0; victimTag = 27'h0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) victimData = '1;
      `CHK("wbReq", memReq, 1'b1);
      `CHK("wbWe", memWe, 1'b1);
      `CHK("wbAddr", memAddr, {27'h7, 3'd2, 2'(k)});
      `CHK("wbData", memWData, (k == 0) ? 32'h100 : 32'h0);
      waitEdge();
    end
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin missReq = 1'b1; missTag = 27'h66; end
      if (k == 2) missReq = 1'b0;
      `CHK("dFillWe", memWe, 1'b0);
      `CHK("dFillAddr", memAddr, {27'h55, 3'd2, 2'(k)});
      waitEdge();
    end
    `CHK("dRegWrite", regWrite, 4'hF);
    `CHK("dWriteData", writeData, FILL_LINE);
    `CHK("dWriteTag", writeTag, 27'h55);
    `CHK("dWriteIdx", writeIdx, 3'd2);
    waitEdge();
    `CHK("dDone", done, 1'b1);
    waitEdge();
    `CHK("dIdleBusy", busy, 1'b0);
    waitEdge();
    `CHK("dNoSecondTxn", busy, 1'b0);
    `CHK("dNoSecondReq", memReq, 1'b0);

    // Clean miss with ack withheld for three cycles on every beat.
    missReq = 1'b1; missTag = 27'h2AAAAAA; missIdx = 3'd7;
    victimValid = 1'b0; victimDirty = 1'b0; memAck = 1'b0;
    waitEdge();
    tReq = cyc;
    missReq = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 4; w++) begin
        memAck = (w == 3);
        `CHK("waitAddr", memAddr, {27'h2AAAAAA, 3'd7, 2'(k)});
        `CHK("waitWData", memWData, 32'h0);
        waitEdge();
      end
    end
    `CHK("waitRegWrite", regWrite, 4'hF);
    `CHK("waitWriteData", writeData, FILL_LINE);
    waitEdge();
    `CHK("waitDone", done, 1'b1);
    `CHK("waitLatency", cyc - tReq + 1, 18);
    waitEdge();

    // Reset asserted in the middle of FILL beat 2.
    missReq = 1'b1; missTag = 27'h0F0F0F0; missIdx = 3'd1;
    victimValid = 1'b1; victimDirty = 1'b0; memAck = 1'b1;
    waitEdge();
    missReq = 1'b0;
    waitEdge();
    waitEdge();
    `CHK("abortBeat2Addr", memAddr, {27'h0F0F0F0, 3'd1, 2'd2});
    #2 reset = 1'b0;
    #1;
    `CHK("abortBusy", busy, 1'b0);
    `CHK("abortReq", memReq, 1'b0);
    `CHK("abortAddr", memAddr, 32'h0);
    `CHK("abortWe", memWe, 1'b0);
    `CHK("abortRegWrite", regWrite, 4'h0);
    `CHK("abortDone", done, 1'b0);
    `CHK("abortWriteData", writeData, 128'h0);
    for (int i = 0; i < 2; i++) begin
      waitEdge();
      `CHK("inRstRegWrite", regWrite, 4'h0);
      `CHK("inRstDone", done, 1'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      waitEdge();
      `CHK("postAbortRegWrite", regWrite, 4'h0);
      `CHK("postAbortDone", done, 1'b0);
      `CHK("postAbortBusy", busy, 1'b0);
    end
    runClean(27'h0ABCDEF, 3'd4, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
